vga_bus_writer: RTL and testbench

VGA_BUS_WRITER -- requirements
Module: vga_bus_writer

---
 rtl/vga_bus_pkg.sv | 47 ++++
 rtl/vga_bus_req_fifo.sv | 66 ++++++
 rtl/vga_bus_writer.sv | 242 ++++++++++++++++++++++++
 tb/tb_vga_bus_writer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_bus_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | vga_bus_pkg: shared constants, state encoding and request entry type   |
// | for the VGA bus writer. Fill support: VGA_BUS_WRITER_FILL_EN.          |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package vga_bus_pkg;

    localparam logic [7:0] DEF_ADDR_X    = 8'hB0;
    localparam logic [7:0] DEF_ADDR_Y    = 8'hB1;
    localparam logic [7:0] DEF_ADDR_DATA = 8'hB2;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SEND_X = 3'd1;
    localparam logic [2:0] ST_SEND_Y = 3'd2;
    localparam logic [2:0] ST_SEND_D = 3'd3;
`ifdef VGA_BUS_WRITER_FILL_EN
    localparam logic [2:0] ST_NEXT   = 3'd4;

    // Fill cursors walk past the screen edge, so they need the 9th bit
    localparam int CUR_XW = 9;
    localparam int CUR_YW = 9;
`else
    localparam int CUR_XW = 8;
    localparam int CUR_YW = 7;
`endif

    typedef struct packed {
`ifdef VGA_BUS_WRITER_FILL_EN
        logic [6:0] h;
        logic [7:0] w;
        logic       fill;
`endif
        logic       pixel;
        logic [6:0] y;
        logic [7:0] x;
    } req_t;

    function automatic logic in_screen(input logic [8:0] cx, input logic [8:0] cy);
        return (cx < 9'(SCREEN_W)) && (cy < 9'(SCREEN_H));
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_bus_req_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | vga_bus_req_fifo: request queue with registered full/empty flags.      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module vga_bus_req_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10: begin
                    empty <= 1'b0;
                    full  <= ((wr_ptr + AW'(1)) == rd_ptr);
                end
                2'b01: begin
                    full  <= 1'b0;
                    empty <= ((rd_ptr + AW'(1)) == wr_ptr);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_bus_writer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | vga_bus_writer: queues pixel requests and writes X/Y/DATA registers    |
// | over a granted bus. Rectangle fill: VGA_BUS_WRITER_FILL_EN. Rev 1.0    |
// +------------------------------------------------------------------------+
module vga_bus_writer
    import vga_bus_pkg::*;
#(
    parameter logic [7:0] ADDR_X     = DEF_ADDR_X,
    parameter logic [7:0] ADDR_Y     = DEF_ADDR_Y,
    parameter logic [7:0] ADDR_DATA  = DEF_ADDR_DATA,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [7:0] REQ_X,
    input  logic [6:0] REQ_Y,
    input  logic       REQ_PIXEL,
`ifdef VGA_BUS_WRITER_FILL_EN
    input  logic       REQ_FILL,
    input  logic [7:0] REQ_W,
    input  logic [6:0] REQ_H,
`endif
    input  logic       BUS_GRANT,
    output logic [7:0] BUS_ADDR,
    output logic [7:0] BUS_DATA,
    output logic       BUS_WE,
    output logic       BUSY
);

    req_t              push_req;
    req_t              head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [2:0]        head_clip;
    logic [8:0]        head_x9;
    logic [8:0]        head_y9;
    logic [CUR_XW-1:0] cur_x;
    logic [CUR_YW-1:0] cur_y;
    logic              pixel;
    logic [7:0]        last_x;
    logic [6:0]        last_y;
    logic              last_x_vld;
    logic              last_y_vld;

    // First state for a pixel: redundant coordinate writes are skipped entirely
    function automatic logic [2:0] first_state(
        input logic [8:0] cx,
        input logic [8:0] cy,
        input logic [2:0] clip_state,
        input logic [7:0] lx,
        input logic       lxv,
        input logic [6:0] ly,
        input logic       lyv
    );
        if (!in_screen(cx, cy)) return clip_state;
        if (!(lxv && lx == cx[7:0])) return ST_SEND_X;
        if (!(lyv && ly == cy[6:0])) return ST_SEND_Y;
        return ST_SEND_D;
    endfunction

    always_comb begin
        push_req       = '0;
        push_req.x     = REQ_X;
        push_req.y     = REQ_Y;
        push_req.pixel = REQ_PIXEL;
`ifdef VGA_BUS_WRITER_FILL_EN
        push_req.fill  = REQ_FILL;
        push_req.w     = REQ_W;
        push_req.h     = REQ_H;
`endif
    end

    vga_bus_req_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .push    (REQ_VALID),
        .wr_data (push_req),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_x9 = {1'b0, head.x};
    assign head_y9 = {2'b0, head.y};

`ifdef VGA_BUS_WRITER_FILL_EN
    logic       fill_act;
    logic [8:0] org_x;
    logic [8:0] end_x;
    logic [8:0] end_y;
    logic [8:0] nx;
    logic [8:0] adv_x;
    logic [8:0] adv_y;
    logic       row_end;
    logic       adv_done;
    logic [7:0] w_eff;
    logic [6:0] h_eff;

    assign head_clip = head.fill ? ST_NEXT : ST_IDLE;
    assign w_eff     = (head.w == 8'd0) ? 8'd1 : head.w;
    assign h_eff     = (head.h == 7'd0) ? 7'd1 : head.h;

    always_comb begin
        nx       = cur_x + 9'd1;
        row_end  = (nx >= end_x);
        adv_x    = row_end ? org_x : nx;
        adv_y    = row_end ? (cur_y + 9'd1) : cur_y;
        adv_done = row_end && ((cur_y + 9'd1) >= end_y);
    end
`else
    assign head_clip = ST_IDLE;
`endif

    // The queue holds requests while the bus is unavailable
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && BUS_GRANT) begin
                    pop      = 1'b1;
                    state_nx = first_state(head_x9, head_y9, head_clip,
                                           last_x, last_x_vld, last_y, last_y_vld);
                end
            end
            ST_SEND_X: begin
                if (BUS_GRANT) begin
                    state_nx = (last_y_vld && last_y == cur_y[6:0]) ? ST_SEND_D : ST_SEND_Y;
                end
            end
            ST_SEND_Y: begin
                if (BUS_GRANT) begin
                    state_nx = ST_SEND_D;
                end
            end
            ST_SEND_D: begin
                if (BUS_GRANT) begin
`ifdef VGA_BUS_WRITER_FILL_EN
                    state_nx = fill_act ? ST_NEXT : ST_IDLE;
`else
                    state_nx = ST_IDLE;
`endif
                end
            end
`ifdef VGA_BUS_WRITER_FILL_EN
            ST_NEXT: begin
                state_nx = adv_done ? ST_IDLE
                         : first_state(adv_x, adv_y, ST_NEXT,
                                       last_x, last_x_vld, last_y, last_y_vld);
            end
`endif
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            cur_x      <= '0;
            cur_y      <= '0;
            pixel      <= 1'b0;
            last_x     <= '0;
            last_y     <= '0;
            last_x_vld <= 1'b0;
            last_y_vld <= 1'b0;
`ifdef VGA_BUS_WRITER_FILL_EN
            fill_act   <= 1'b0;
            org_x      <= '0;
            end_x      <= '0;
            end_y      <= '0;
`endif
        end else begin
            state <= state_nx;
            if (pop) begin
                cur_x <= CUR_XW'(head.x);
                cur_y <= CUR_YW'(head.y);
                pixel <= head.pixel;
`ifdef VGA_BUS_WRITER_FILL_EN
                fill_act <= head.fill;
                org_x    <= head_x9;
                end_x    <= head_x9 + {1'b0, w_eff};
                end_y    <= head_y9 + {2'b0, h_eff};
`endif
            end
`ifdef VGA_BUS_WRITER_FILL_EN
            if (state == ST_NEXT) begin
                cur_x <= adv_x;
                cur_y <= adv_y;
            end
`endif
            if (BUS_GRANT && state == ST_SEND_X) begin
                last_x     <= cur_x[7:0];
                last_x_vld <= 1'b1;
            end
            if (BUS_GRANT && state == ST_SEND_Y) begin
                last_y     <= cur_y[6:0];
                last_y_vld <= 1'b1;
            end
        end
    end

    always_comb begin
        BUS_WE   = 1'b0;
        BUS_ADDR = '0;
        BUS_DATA = '0;
        if (BUS_GRANT) begin
            case (state)
                ST_SEND_X: begin
                    BUS_WE   = 1'b1;
                    BUS_ADDR = ADDR_X;
                    BUS_DATA = cur_x[7:0];
                end
                ST_SEND_Y: begin
                    BUS_WE   = 1'b1;
                    BUS_ADDR = ADDR_Y;
                    BUS_DATA = {1'b0, cur_y[6:0]};
                end
                ST_SEND_D: begin
                    BUS_WE   = 1'b1;
                    BUS_ADDR = ADDR_DATA;
                    BUS_DATA = {7'b0, pixel};
                end
                default: ;
            endcase
        end
    end

    assign REQ_READY = !RESET && !fifo_full;
    assign BUSY      = !fifo_empty || (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vga_bus_writer.sv
`default_nettype none
// Bench for vga_bus_writer: a pixel-list model predicts every bus write,
// directed tests pin the model with literal values.
module tb_vga_bus_writer;

    localparam int A_X = 'hB0;
    localparam int A_Y = 'hB1;
    localparam int A_D = 'hB2;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       REQ_VALID = 1'b0;
    logic [7:0] REQ_X = '0;
    logic [6:0] REQ_Y = '0;
    logic       REQ_PIXEL = 1'b0;
    logic       BUS_GRANT = 1'b0;
`ifdef VGA_BUS_WRITER_FILL_EN
    logic       REQ_FILL = 1'b0;
    logic [7:0] REQ_W = '0;
    logic [6:0] REQ_H = '0;
`endif
    logic       REQ_READY;
    logic [7:0] BUS_ADDR;
    logic [7:0] BUS_DATA;
    logic       BUS_WE;
    logic       BUSY;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;

    int exp_a[$];
    int exp_d[$];
    int log_a[$];
    int log_d[$];
    int log_c[$];
    int mlx = 0;
    int mly = 0;
    bit mlxv = 0;
    bit mlyv = 0;

    vga_bus_writer dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_X     (REQ_X),
        .REQ_Y     (REQ_Y),
        .REQ_PIXEL (REQ_PIXEL),
`ifdef VGA_BUS_WRITER_FILL_EN
        .REQ_FILL  (REQ_FILL),
        .REQ_W     (REQ_W),
        .REQ_H     (REQ_H),
`endif
        .BUS_GRANT (BUS_GRANT),
        .BUS_ADDR  (BUS_ADDR),
        .BUS_DATA  (BUS_DATA),
        .BUS_WE    (BUS_WE),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string n, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, act, req);
        end
    endtask

    // Expand a request into the write list it must produce
    task automatic model_accept(input int x, input int y, input int p,
                                input int f, input int w, input int h);
        int we;
        int he;
        we = (f != 0) ? ((w == 0) ? 1 : w) : 1;
        he = (f != 0) ? ((h == 0) ? 1 : h) : 1;
        for (int r = y; r < y + he; r++) begin
            for (int c = x; c < x + we; c++) begin
                if (c < 160 && r < 120) begin
                    if (!(mlxv && mlx == c)) begin
                        exp_a.push_back(A_X); exp_d.push_back(c);
                        mlx = c; mlxv = 1;
                    end
                    if (!(mlyv && mly == r)) begin
                        exp_a.push_back(A_Y); exp_d.push_back(r);
                        mly = r; mlyv = 1;
                    end
                    exp_a.push_back(A_D); exp_d.push_back(p);
                end
            end
        end
    endtask

    always @(posedge CLK) begin
        cyc = cyc + 1;
        if (RESET) begin
            exp_a.delete(); exp_d.delete();
            mlxv = 0; mlyv = 0;
        end else if (REQ_VALID && REQ_READY) begin
            last_acc = cyc;
`ifdef VGA_BUS_WRITER_FILL_EN
            model_accept(REQ_X, REQ_Y, REQ_PIXEL, REQ_FILL, REQ_W, REQ_H);
`else
            model_accept(REQ_X, REQ_Y, REQ_PIXEL, 0, 0, 0);
`endif
        end
    end

    // Cycle index recorded is the edge that closes the sampled cycle
    always @(negedge CLK) begin
        if (!RESET) begin
            if (BUS_WE) begin
                log_a.push_back(BUS_ADDR); log_d.push_back(BUS_DATA); log_c.push_back(cyc + 1);
                if (exp_a.size() == 0) begin
                    chk("unexpected_write", BUS_ADDR, 0);
                end else begin
                    chk("bus_addr", BUS_ADDR, exp_a[0]);
                    chk("bus_data", BUS_DATA, exp_d[0]);
                    void'(exp_a.pop_front());
                    void'(exp_d.pop_front());
                end
            end else begin
                chk("idle_addr", BUS_ADDR, 0);
                chk("idle_data", BUS_DATA, 0);
            end
        end
    end

    task automatic push(input int x, input int y, input int p, input int f, input int w, input int h);
        @(posedge CLK); #1;
        REQ_VALID = 1'b1;
        REQ_X = x[7:0]; REQ_Y = y[6:0]; REQ_PIXEL = p[0];
`ifdef VGA_BUS_WRITER_FILL_EN
        REQ_FILL = f[0]; REQ_W = w[7:0]; REQ_H = h[6:0];
`else
        if (f != 0 || w != 0 || h != 0) $display("note: fill arguments ignored");
`endif
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
    endtask

    task automatic wait_idle(input string n, output int idle_c);
        bit done;
        done = 0;
        idle_c = -1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge CLK);
            if (!BUSY && exp_a.size() == 0) begin
                done = 1;
                idle_c = cyc + 1;
            end
        end
        if (!done) chk({n, "_timeout"}, 0, 1);
    endtask

    task automatic wait_write(input string n, input int addr);
        bit done;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge CLK);
            if (BUS_WE && BUS_ADDR == addr[7:0]) done = 1;
        end
        if (!done) chk({n, "_timeout"}, 0, 1);
    endtask

    task automatic log_clear();
        log_a.delete(); log_d.delete(); log_c.delete();
    endtask

    task automatic chk_log(input string n, input int idx, input int a, input int d);
        if (idx < log_a.size()) begin
            chk({n, "_addr"}, log_a[idx], a);
            chk({n, "_data"}, log_d[idx], d);
        end else begin
            chk({n, "_missing"}, -1, idx);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle_c;
        int acc;
        logic rdy [5];

        BUS_GRANT = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_we", BUS_WE, 0);
        chk("rst_addr", BUS_ADDR, 0);
        chk("rst_data", BUS_DATA, 0);
        chk("rst_ready", REQ_READY, 0);
        chk("rst_busy", BUSY, 0);
        RESET = 1'b0;
        #1;
        chk("ready_after_rst", REQ_READY, 1);

        // Single pixel after reset: full three-write sequence
        log_clear();
        push(10, 20, 1, 0, 0, 0);
        acc = last_acc;
        wait_idle("px1", idle_c);
        chk("px1_count", log_a.size(), 3);
        chk_log("px1_w0", 0, 'hB0, 'h0A);
        chk_log("px1_w1", 1, 'hB1, 'h14);
        chk_log("px1_w2", 2, 'hB2, 'h01);
        if (log_c.size() == 3) begin
            chk("px1_latency", log_c[0] - acc, 2);
            chk("px1_span", log_c[2] - log_c[0], 2);
            chk("px1_busy_fall", idle_c - log_c[2], 1);
        end

        // Same row: Y write skipped
        log_clear();
        push(11, 20, 0, 0, 0, 0);
        wait_idle("px2", idle_c);
        chk("px2_count", log_a.size(), 2);
        chk_log("px2_w0", 0, 'hB0, 'h0B);
        chk_log("px2_w1", 1, 'hB2, 'h00);

        // Off-screen pixels vanish and leave the shadows alone
        log_clear();
        push(200, 20, 1, 0, 0, 0);
        push(11, 120, 1, 0, 0, 0);
        wait_idle("clip", idle_c);
        chk("clip_count", log_a.size(), 0);
        push(11, 20, 1, 0, 0, 0);
        wait_idle("px3", idle_c);
        chk("px3_count", log_a.size(), 1);
        chk_log("px3_w0", 0, 'hB2, 'h01);

        // Fill the queue with the bus withheld
        log_clear();
        @(posedge CLK); #1;
        BUS_GRANT = 1'b0;
        REQ_VALID = 1'b1;
        for (int k = 0; k < 5; k++) begin
            REQ_X = 8'(100 + k); REQ_Y = 7'(k); REQ_PIXEL = k[0];
            rdy[k] = REQ_READY;
            @(posedge CLK); #1;
        end
        REQ_VALID = 1'b0;
        chk("q_ready3", rdy[3], 1);
        chk("q_ready4", rdy[4], 0);
        chk("q_ready_full", REQ_READY, 0);
        chk("q_busy", BUSY, 1);
        chk("q_no_write", log_a.size(), 0);
        BUS_GRANT = 1'b1;
        wait_idle("q", idle_c);
        chk("q_count", log_a.size(), 12);
        chk_log("q_p0", 0, 'hB0, 'h64);
        chk_log("q_p1", 3, 'hB0, 'h65);
        chk_log("q_p2", 6, 'hB0, 'h66);
        chk_log("q_p3", 9, 'hB0, 'h67);
        chk_log("q_p3d", 11, 'hB2, 'h01);

        // Grant drops for one cycle during the Y write
        log_clear();
        push(70, 80, 1, 0, 0, 0);
        wait_write("stall", A_X);
        @(posedge CLK); #1;
        BUS_GRANT = 1'b0;
        @(negedge CLK);
        chk("stall_we", BUS_WE, 0);
        chk("stall_addr", BUS_ADDR, 0);
        chk("stall_data", BUS_DATA, 0);
        @(posedge CLK); #1;
        BUS_GRANT = 1'b1;
        @(negedge CLK);
        chk("resume_we", BUS_WE, 1);
        chk("resume_addr", BUS_ADDR, 'hB1);
        chk("resume_data", BUS_DATA, 'h50);
        wait_idle("stall", idle_c);
        chk("stall_count", log_a.size(), 3);

        // Reset mid-pixel, then the same pixel needs all three writes
        push(50, 60, 1, 0, 0, 0);
        wait_write("rstmid", A_Y);
        #2;
        RESET = 1'b1;
        #1;
        chk("rstmid_we", BUS_WE, 0);
        chk("rstmid_addr", BUS_ADDR, 0);
        chk("rstmid_busy", BUSY, 0);
        chk("rstmid_ready", REQ_READY, 0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        #1;
        chk("rstmid_ready_after", REQ_READY, 1);
        chk("rstmid_busy_after", BUSY, 0);
        log_clear();
        push(50, 60, 1, 0, 0, 0);
        wait_idle("rep", idle_c);
        chk("rep_count", log_a.size(), 3);
        chk_log("rep_w0", 0, 'hB0, 'h32);
        chk_log("rep_w1", 1, 'hB1, 'h3C);
        chk_log("rep_w2", 2, 'hB2, 'h01);

`ifdef VGA_BUS_WRITER_FILL_EN
        // Rectangle clipped at the bottom-right corner
        log_clear();
        push(158, 119, 1, 1, 4, 2);
        wait_idle("fill", idle_c);
        chk("fill_count", log_a.size(), 5);
        chk_log("fill_w0", 0, 'hB0, 'h9E);
        chk_log("fill_w1", 1, 'hB1, 'h77);
        chk_log("fill_w2", 2, 'hB2, 'h01);
        chk_log("fill_w3", 3, 'hB0, 'h9F);
        chk_log("fill_w4", 4, 'hB2, 'h01);
`endif

        repeat (2) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
